gshare_btb_predictor: RTL and testbench
=======================================

// Module: gshare_btb_predictor
// PURPOSE
//  Parametrised gshare direction predictor with a tagged BTB, used by IF/ID for br/jmp/jsr/trap.
//  Differences from the previous generation:
//   - table sizes and counter width are parameters;
//   - speculative global history, repaired from EX/MEM on a mispredict;
//   - BTB entries carry valid + tag;
//   - synchronous reset runs a table-clearing init sequence.
// PARAMETERS
//  INDEX_BITS  8   PHT and BTB each hold 2**INDEX_BITS entries
//  HIST_BITS   8   global history length; must be <= INDEX_BITS
//  CTR_BITS    2   saturating counter width
//  TAG_BITS    7   BTB tag width; INDEX_BITS+TAG_BITS <= 15
// PORTS
//  clk            in   1          clock
//  rst            in   1          synchronous reset, active-high
//  init_done      out  1          1 = tables cleared, predictor live
//  stall          in   1          pipeline stall; freezes lookup path
//  lookup_valid   in   1          IF has a decoded control-flow op (br/jmp/jsr/trap) at lookup_pc
//  lookup_pc      in   16         PC of that op
//  pred_valid     out  1          pred_* outputs carry a prediction
//  pred_taken     out  1          predicted taken
//  pred_target    out  16         predicted target (BTB data)
//  pred_hist      out  HIST_BITS  history used for this prediction; carried down the pipe
//  upd_valid      in   1          EX/MEM resolved a control-flow op
//  upd_pc         in   16         PC of the resolved op
//  upd_hist       in   HIST_BITS  pred_hist carried with the op
//  upd_taken      in   1          actual direction
//  upd_target     in   16         actual target
//  upd_mispredict in   1          direction or target was mispredicted (qualified by upd_valid)
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; spec_hist 0.
//   - rst forces state INIT, index counter 0.
//   - rst asserted at any time, including mid-INIT, restarts INIT.
//  INIT: one entry per cycle for 2**INDEX_BITS cycles.
//   - PHT[i] = 2**(CTR_BITS-1)-1 (weakly not-taken); BTB valid[i] = 0.
//   - lookups and updates are ignored; pred_valid = 0.
//   - after the last entry: state RUN, init_done = 1 (registered).
//  Indexing:
//   - pidx = pc[INDEX_BITS:1] ^ zero-extended history.
//   - bidx = pc[INDEX_BITS:1]; tag = pc[INDEX_BITS+TAG_BITS:INDEX_BITS+1].
//  Lookup, RUN state, 1-cycle latency:
//   - inputs are sampled at a posedge with lookup_valid=1 and stall=0; pred_* are registered on that edge.
//   - hit = BTB valid & tag match.
//   - pred_taken = PHT MSB & hit; pred_target = BTB data on a hit, else 0.
//   - pred_hist = spec_hist before the shift.
//   - spec_hist <= {spec_hist[HIST_BITS-2:0], pred_taken}.
//   - lookup_valid=0 and stall=0: pred_valid <= 0.
//   - stall=1: all pred_* and spec_hist hold.
//  Update, RUN state, when upd_valid=1; applies regardless of stall:
//   - PHT[upd pidx from upd_hist] saturating +1 if taken, -1 if not taken.
//   - Saturates at all-ones / zero; no wrap.
//   - upd_taken=1: BTB[bidx] <= {valid=1, tag, upd_target}. Not-taken leaves the BTB untouched.
//   - upd_mispredict=1: spec_hist <= {upd_hist[HIST_BITS-2:0], upd_taken}.
//  Simultaneous events:
//   - mispredict + lookup in the same cycle: repair wins; the lookup is dropped; pred_valid <= 0.
//   - update and lookup to the same entry in the same cycle: the lookup sees the old contents.
//   - Updated data is visible from the next cycle.
// TESTING
//  1. Reset timing: rst for 1 cycle -> init_done=0 for exactly 256 cycles, then 1.
//     Then lookup pc 0x0040 -> pred_valid=1, pred_taken=0.
//  2. Training: spec_hist=0. upd pc=0x0040, hist=0, taken, target=0x0080 -> next lookup 0x0040 gives
//     taken, target 0x0080. Then 4 more taken and 2 not-taken updates -> counter 01, pred_taken=0.
//  3. Tag alias: train 0x0040 taken, then lookup 0x0240 (same bidx, different tag) -> pred_taken=0.
//  4. History repair: 3 taken predictions -> pred_hist sequence 0x00,0x01,0x03.
//     Then mispredict with upd_hist=0x05, upd_taken=0 -> next lookup pred_hist=0x0A.
//  5. Conflicts: mispredict and lookup in the same cycle -> pred_valid=0.
//     stall=1 for 3 cycles -> pred_* and spec_hist unchanged.
//  6. Reset mid-INIT: rst at INIT cycle 100 -> init_done rises 256 cycles after rst deasserts.
//     No prior training survives.

Source files
------------

// File: rtl/gshare_btb_predictor.sv
// gshare direction predictor with a tagged BTB. Speculative global history is repaired on a mispredict;
// every synchronous reset starts a one-entry-per-cycle sweep that clears both tables.
module gshare_btb_predictor #(
   parameter int INDEX_BITS = 8,
   parameter int HIST_BITS  = 8,
   parameter int CTR_BITS   = 2,
   parameter int TAG_BITS   = 7
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   output logic                 init_done_o,
   input  logic                 stall_i,
   input  logic                 lookup_valid_i,
   input  logic [15:0]          lookup_pc_i,
   output logic                 pred_valid_o,
   output logic                 pred_taken_o,
   output logic [15:0]          pred_target_o,
   output logic [HIST_BITS-1:0] pred_hist_o,
   input  logic                 upd_valid_i,
   input  logic [15:0]          upd_pc_i,
   input  logic [HIST_BITS-1:0] upd_hist_i,
   input  logic                 upd_taken_i,
   input  logic [15:0]          upd_target_i,
   input  logic                 upd_mispredict_i
);

   localparam int                    ENTRIES     = 1 << INDEX_BITS;
   localparam logic [CTR_BITS-1:0]   CTR_ONE     = {{(CTR_BITS-1){1'b0}}, 1'b1};
   localparam logic [CTR_BITS-1:0]   CTR_MAX     = {CTR_BITS{1'b1}};
   localparam logic [CTR_BITS-1:0]   CTR_WEAK_NT = {1'b0, {(CTR_BITS-1){1'b1}}};
   localparam logic [INDEX_BITS-1:0] IDX_LAST    = {INDEX_BITS{1'b1}};
   localparam logic [INDEX_BITS-1:0] IDX_ONE     = {{(INDEX_BITS-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

   function automatic logic [CTR_BITS-1:0] ctr_next(input logic [CTR_BITS-1:0] ctr,
                                                    input logic                taken);
      logic [CTR_BITS-1:0] res;
      res = ctr;
      if (taken) begin
         if (ctr != CTR_MAX) res = ctr + CTR_ONE;
         else                res = ctr;
      end else begin
         if (ctr != {CTR_BITS{1'b0}}) res = ctr - CTR_ONE;
         else                         res = ctr;
      end
      return res;
   endfunction

   state_t                state_q, state_d;
   logic [INDEX_BITS-1:0] idx_q, idx_d;
   logic                  init_done_q, init_done_d;
   logic                  pred_valid_q, pred_valid_d;
   logic                  pred_taken_q, pred_taken_d;
   logic [15:0]           pred_target_q, pred_target_d;
   logic [HIST_BITS-1:0]  pred_hist_q, pred_hist_d;
   logic [HIST_BITS-1:0]  spec_hist_q, spec_hist_d;

   logic [CTR_BITS-1:0]   pht_q        [ENTRIES];
   logic                  btb_valid_q  [ENTRIES];
   logic [TAG_BITS-1:0]   btb_tag_q    [ENTRIES];
   logic [15:0]           btb_target_q [ENTRIES];

   logic [INDEX_BITS-1:0] lk_bidx_s, lk_pidx_s, upd_bidx_s, upd_pidx_s;
   logic [TAG_BITS-1:0]   lk_tag_s, upd_tag_s;
   logic                  lk_hit_s, lk_taken_s;
   logic [15:0]           lk_target_s;
   logic                  unused_pc_s;

   assign lk_bidx_s   = lookup_pc_i[INDEX_BITS:1];
   assign lk_pidx_s   = lk_bidx_s ^ INDEX_BITS'(spec_hist_q);
   assign lk_tag_s    = lookup_pc_i[INDEX_BITS+TAG_BITS:INDEX_BITS+1];
   assign lk_hit_s    = btb_valid_q[lk_bidx_s] && (btb_tag_q[lk_bidx_s] == lk_tag_s);
   assign lk_taken_s  = pht_q[lk_pidx_s][CTR_BITS-1] & lk_hit_s;
   assign lk_target_s = lk_hit_s ? btb_target_q[lk_bidx_s] : 16'h0000;

   assign upd_bidx_s  = upd_pc_i[INDEX_BITS:1];
   assign upd_pidx_s  = upd_bidx_s ^ INDEX_BITS'(upd_hist_i);
   assign upd_tag_s   = upd_pc_i[INDEX_BITS+TAG_BITS:INDEX_BITS+1];
   assign unused_pc_s = ^{lookup_pc_i, upd_pc_i};

   // Control and prediction registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_INIT;
         idx_q         <= {INDEX_BITS{1'b0}};
         init_done_q   <= 1'b0;
         pred_valid_q  <= 1'b0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= 16'h0000;
         pred_hist_q   <= {HIST_BITS{1'b0}};
         spec_hist_q   <= {HIST_BITS{1'b0}};
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         init_done_q   <= init_done_d;
         pred_valid_q  <= pred_valid_d;
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
         pred_hist_q   <= pred_hist_d;
         spec_hist_q   <= spec_hist_d;
      end
   end

   // Next state: init sweep, then lookup / history repair.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      init_done_d   = init_done_q;
      pred_valid_d  = pred_valid_q;
      pred_taken_d  = pred_taken_q;
      pred_target_d = pred_target_q;
      pred_hist_d   = pred_hist_q;
      spec_hist_d   = spec_hist_q;
      case (state_q)
         ST_INIT: begin
            pred_valid_d = 1'b0;
            idx_d        = idx_q + IDX_ONE;
            if (idx_q == IDX_LAST) begin
               state_d     = ST_RUN;
               init_done_d = 1'b1;
            end else begin
               state_d     = ST_INIT;
            end
         end
         ST_RUN: begin
            // Repair beats a same-cycle lookup; the lookup is simply dropped.
            if (upd_valid_i && upd_mispredict_i) begin
               spec_hist_d = {upd_hist_i[HIST_BITS-2:0], upd_taken_i};
            end else if (!stall_i && lookup_valid_i) begin
               spec_hist_d = {spec_hist_q[HIST_BITS-2:0], lk_taken_s};
            end else begin
               spec_hist_d = spec_hist_q;
            end
            if (stall_i) begin
               pred_valid_d = pred_valid_q;
            end else if (upd_valid_i && upd_mispredict_i) begin
               pred_valid_d = 1'b0;
            end else if (lookup_valid_i) begin
               pred_valid_d  = 1'b1;
               pred_taken_d  = lk_taken_s;
               pred_target_d = lk_target_s;
               pred_hist_d   = spec_hist_q;
            end else begin
               pred_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = ST_INIT;
            idx_d       = {INDEX_BITS{1'b0}};
            init_done_d = 1'b0;
         end
      endcase
   end

   // Pattern history table: cleared during init, trained by resolved ops.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (state_q == ST_INIT) pht_q[idx_q] <= CTR_WEAK_NT;
         else if (upd_valid_i)   pht_q[upd_pidx_s] <= ctr_next(pht_q[upd_pidx_s], upd_taken_i);
      end
   end

   // BTB: only taken ops allocate or refresh an entry.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         if (state_q == ST_INIT) begin
            btb_valid_q[idx_q] <= 1'b0;
         end else if (upd_valid_i && upd_taken_i) begin
            btb_valid_q[upd_bidx_s]  <= 1'b1;
            btb_tag_q[upd_bidx_s]    <= upd_tag_s;
            btb_target_q[upd_bidx_s] <= upd_target_i;
         end
      end
   end

   assign init_done_o   = init_done_q;
   assign pred_valid_o  = pred_valid_q;
   assign pred_taken_o  = pred_taken_q;
   assign pred_target_o = pred_target_q;
   assign pred_hist_o   = pred_hist_q;

endmodule

// File: tb/tb_gshare_btb_predictor.sv
// Directed bench for gshare_btb_predictor: expected prediction vectors are queued per driven cycle
// and checked one cycle later on the falling edge.
module tb_gshare_btb_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic        init_done;
   logic        stall, lookup_valid;
   logic [15:0] lookup_pc;
   logic        pred_valid, pred_taken;
   logic [15:0] pred_target;
   logic [7:0]  pred_hist;
   logic        upd_valid, upd_taken, upd_mispredict;
   logic [15:0] upd_pc, upd_target;
   logic [7:0]  upd_hist;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic        full;
      logic [25:0] v;
   } exp_t;
   exp_t sb_q[$];

   logic [25:0] pred_vec;
   assign pred_vec = {pred_valid, pred_taken, pred_target, pred_hist};

   gshare_btb_predictor dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .init_done_o     (init_done),
      .stall_i         (stall),
      .lookup_valid_i  (lookup_valid),
      .lookup_pc_i     (lookup_pc),
      .pred_valid_o    (pred_valid),
      .pred_taken_o    (pred_taken),
      .pred_target_o   (pred_target),
      .pred_hist_o     (pred_hist),
      .upd_valid_i     (upd_valid),
      .upd_pc_i        (upd_pc),
      .upd_hist_i      (upd_hist),
      .upd_taken_i     (upd_taken),
      .upd_target_i    (upd_target),
      .upd_mispredict_i(upd_mispredict)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
      end
   endtask

   task automatic idle();
      stall = 1'b0; lookup_valid = 1'b0; lookup_pc = 16'h0000;
      upd_valid = 1'b0; upd_pc = 16'h0000; upd_hist = 8'h00;
      upd_taken = 1'b0; upd_target = 16'h0000; upd_mispredict = 1'b0;
   endtask

   // One clock of stimulus; the expected pred_* vector is queued and checked after the edge.
   task automatic step(input string name, input logic lv, input logic [15:0] pc, input logic st,
                       input logic uv, input logic [15:0] upc, input logic [7:0] uh,
                       input logic ut, input logic [15:0] utg, input logic um,
                       input logic full, input logic [25:0] ev);
      exp_t e;
      lookup_valid = lv; lookup_pc = pc; stall = st;
      upd_valid = uv; upd_pc = upc; upd_hist = uh;
      upd_taken = ut; upd_target = utg; upd_mispredict = um;
      sb_q.push_back({full, ev});
      @(negedge clk);
      e = sb_q.pop_front();
      if (e.full) chk(name, 32'(pred_vec), 32'(e.v));
      else        chk(name, 32'(pred_valid), 32'(e.v[25]));
   endtask

   task automatic lk(input string name, input logic [15:0] pc, input logic et,
                     input logic [15:0] etg, input logic [7:0] eh);
      step(name, 1'b1, pc, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000, 1'b0,
           1'b1, {1'b1, et, etg, eh});
   endtask

   task automatic upd(input string name, input logic [15:0] pc, input logic [7:0] h,
                      input logic t, input logic [15:0] tg, input logic m);
      step(name, 1'b0, 16'h0000, 1'b0, 1'b1, pc, h, t, tg, m, 1'b0, 26'h0);
   endtask

   // Counts falling-edge samples with init_done low, starting at the sample after the last reset edge.
   task automatic wait_init(input string name);
      int cnt;
      cnt = 0;
      while (init_done !== 1'b1 && cnt < 1000) begin
         chk({name, "_pred_valid"}, 32'(pred_valid), 32'h0);
         cnt++;
         @(negedge clk);
      end
      chk(name, 32'(cnt), 32'd256);
   endtask

   initial begin
      rst = 1'b1;
      idle();
      repeat (3) @(negedge clk);
      chk("reset_outputs", 32'({init_done, pred_vec}), 32'h0);
      rst = 1'b0;
      wait_init("init_len");

      lk("first_lookup", 16'h0040, 1'b0, 16'h0000, 8'h00);

      upd("train_t1", 16'h0040, 8'h00, 1'b1, 16'h0080, 1'b0);
      lk("trained_hit", 16'h0040, 1'b1, 16'h0080, 8'h00);
      for (int i = 0; i < 4; i++) upd("train_t", 16'h0040, 8'h00, 1'b1, 16'h0080, 1'b0);
      upd("train_nt_rep1", 16'h0040, 8'h00, 1'b0, 16'h0000, 1'b1);
      lk("sat_high", 16'h0040, 1'b1, 16'h0080, 8'h00);
      upd("train_nt_rep2", 16'h0040, 8'h00, 1'b0, 16'h0000, 1'b1);
      lk("ctr_01", 16'h0040, 1'b0, 16'h0080, 8'h00);
      upd("dec_to_00", 16'h0040, 8'h00, 1'b0, 16'h0000, 1'b0);
      upd("dec_sat_00", 16'h0040, 8'h00, 1'b0, 16'h0000, 1'b0);
      upd("inc_01", 16'h0040, 8'h00, 1'b1, 16'h0080, 1'b0);
      upd("inc_10", 16'h0040, 8'h00, 1'b1, 16'h0080, 1'b0);
      lk("sat_low", 16'h0040, 1'b1, 16'h0080, 8'h00);

      upd("repair_to_0", 16'h1000, 8'h00, 1'b0, 16'h0000, 1'b1);
      lk("tag_alias", 16'h0240, 1'b0, 16'h0000, 8'h00);

      upd("train_h1", 16'h0040, 8'h01, 1'b1, 16'h0080, 1'b0);
      upd("train_h3", 16'h0040, 8'h03, 1'b1, 16'h0080, 1'b0);
      lk("hist_00", 16'h0040, 1'b1, 16'h0080, 8'h00);
      lk("hist_01", 16'h0040, 1'b1, 16'h0080, 8'h01);
      lk("hist_03", 16'h0040, 1'b1, 16'h0080, 8'h03);
      upd("repair_05", 16'h0040, 8'h05, 1'b0, 16'h0000, 1'b1);
      lk("hist_0a", 16'h0040, 1'b0, 16'h0080, 8'h0a);

      step("mispredict_vs_lookup", 1'b1, 16'h0040, 1'b0, 1'b1, 16'h1000, 8'h00, 1'b0,
           16'h0000, 1'b1, 1'b0, 26'h0);
      lk("repair_won", 16'h0040, 1'b1, 16'h0080, 8'h00);
      for (int i = 0; i < 3; i++)
         step("stall_hold", 1'b1, 16'h0240, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 16'h0000,
              1'b0, 1'b1, {1'b1, 1'b1, 16'h0080, 8'h00});
      lk("after_stall", 16'h0040, 1'b1, 16'h0080, 8'h01);

      idle();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_clears_outputs", 32'({init_done, pred_vec}), 32'h0);
      repeat (100) @(negedge clk);
      chk("mid_init_busy", 32'(init_done), 32'h0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      lookup_valid = 1'b1; lookup_pc = 16'h0040;
      upd_valid = 1'b1; upd_pc = 16'h0040; upd_hist = 8'h05;
      upd_taken = 1'b1; upd_target = 16'h1234; upd_mispredict = 1'b1;
      wait_init("reinit_len");
      idle();
      lk("after_reinit", 16'h0040, 1'b0, 16'h0000, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
